// File: rtl/line_window_if.sv
// Pixel stream in, 3x3 window out. The master drives raster pixels and the
// slave (window generator) returns the registered window.
interface line_window_if;
  logic [7:0] pix_in;
  logic       pix_valid;
  logic       frame_start;
  logic [7:0] p1, p2, p3, p4, p5, p6, p7, p8, p9;
  logic       win_valid;
  logic       frame_end;

  modport master (
    output pix_in, pix_valid, frame_start,
    input  p1, p2, p3, p4, p5, p6, p7, p8, p9, win_valid, frame_end
  );

  modport slave (
    input  pix_in, pix_valid, frame_start,
    output p1, p2, p3, p4, p5, p6, p7, p8, p9, win_valid, frame_end
  );
endinterface

// File: rtl/line_window_3x3.sv
// 3x3 sliding window over a raster stream using two line buffers.
// One window per accepted beat once two full lines are buffered; no padding.
module line_window_3x3 #(
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  line_window_if.slave bus
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  typedef enum logic {FILL, RUN} state_e;

  state_e               state_q, state_d, state_cur;
  logic [CW-1:0]        col_q, col_d, col_cur;
  logic [RW-1:0]        row_q, row_d, row_cur;
  logic [8:0][7:0]      win_q, win_d;
  logic                 wv_q, wv_d, fe_q, fe_d;
  logic                 beat, eol, eof;
  logic [7:0]           up1, up2;
  logic [7:0]           lb1_q [IMG_WIDTH];
  logic [7:0]           lb2_q [IMG_WIDTH];

  // frame_start overrides the counters so the beat lands on (0,0) in FILL.
  always_comb begin
    beat      = bus.pix_valid;
    col_cur   = bus.frame_start ? '0 : col_q;
    row_cur   = bus.frame_start ? '0 : row_q;
    state_cur = bus.frame_start ? FILL : state_q;
    up1       = lb1_q[col_cur];
    up2       = lb2_q[col_cur];
    eol       = (col_cur == COL_LAST);
    eof       = eol && (row_cur == ROW_LAST);
    col_d     = col_q;
    row_d     = row_q;
    state_d   = state_q;
    win_d     = win_q;
    wv_d      = 1'b0;
    fe_d      = 1'b0;
    if (beat) begin
      col_d = eol ? '0 : col_cur + CW'(1);
      row_d = eof ? '0 : (eol ? row_cur + RW'(1) : row_cur);
      if (eof)                             state_d = FILL;
      else if (eol && row_cur == RW'(1))   state_d = RUN;
      else                                 state_d = state_cur;
      win_d[0] = win_q[1];
      win_d[1] = win_q[2];
      win_d[2] = up2;
      win_d[3] = win_q[4];
      win_d[4] = win_q[5];
      win_d[5] = up1;
      win_d[6] = win_q[7];
      win_d[7] = win_q[8];
      win_d[8] = bus.pix_in;
      // RUN implies row >= 2; col >= 2 keeps windows inside one line.
      wv_d = (state_cur == RUN) && (col_cur >= CW'(2));
      fe_d = wv_d && eof;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      col_q   <= '0;
      row_q   <= '0;
      win_q   <= '0;
      wv_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      win_q   <= win_d;
      wv_q    <= wv_d;
      fe_q    <= fe_d;
    end
  end

  // Line memories are never reset; FILL keeps stale data out of windows.
  always_ff @(posedge clk) begin
    if (beat) begin
      lb1_q[col_cur] <= bus.pix_in;
      lb2_q[col_cur] <= up1;
    end
  end

  assign bus.p1        = win_q[0];
  assign bus.p2        = win_q[1];
  assign bus.p3        = win_q[2];
  assign bus.p4        = win_q[3];
  assign bus.p5        = win_q[4];
  assign bus.p6        = win_q[5];
  assign bus.p7        = win_q[6];
  assign bus.p8        = win_q[7];
  assign bus.p9        = win_q[8];
  assign bus.win_valid = wv_q;
  assign bus.frame_end = fe_q;
endmodule

// File: tb/tb_line_window_3x3.sv
// Directed vector table on a 4x4 instance plus a random-stall scoreboard run
// on a 64x64 instance.
module tb_line_window_3x3;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  line_window_if sif();
  line_window_if bif();

  line_window_3x3 #(.IMG_WIDTH(4), .IMG_HEIGHT(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .bus(sif)
  );
  line_window_3x3 #(.IMG_WIDTH(64), .IMG_HEIGHT(64)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bif)
  );

  typedef struct packed {
    logic            v;
    logic            fs;
    logic [7:0]      pix;
    logic            wv;
    logic            fe;
    logic            chk;
    logic [8:0][7:0] p;   // p[0]=p1 .. p[8]=p9
  } vec_t;

  vec_t q[$];
  vec_t last_e;
  int   pass_cnt = 0;
  int   tot_cnt  = 0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Expected window for 4x4 frames: pixel = base + r*16 + c.
  function automatic logic [8:0][7:0] model_win(input logic [7:0] base, input int r, input int c);
    logic [8:0][7:0] w;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[i*3+j] = 8'(int'(base) + (r-2+i)*16 + (c-2+j));
    return w;
  endfunction

  task automatic push_beat(input logic [7:0] base, input int r, input int c, input logic fs);
    vec_t e;
    e.v   = 1'b1;
    e.fs  = fs;
    e.pix = 8'(int'(base) + r*16 + c);
    e.wv  = (r >= 2) && (c >= 2);
    e.fe  = e.wv && (r == 3) && (c == 3);
    e.chk = e.wv;
    e.p   = model_win(base, r, c);
    q.push_back(e);
    last_e = e;
  endtask

  // Stall: outputs hold the previous beat's values, valid/end drop.
  task automatic push_stall(input logic fs);
    vec_t e;
    e     = last_e;
    e.v   = 1'b0;
    e.fs  = fs;
    e.pix = 8'hEE;
    e.wv  = 1'b0;
    e.fe  = 1'b0;
    q.push_back(e);
    last_e = e;
  endtask

  task automatic push_frame(input logic [7:0] base, input logic fs_first);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        push_beat(base, r, c, fs_first && r == 0 && c == 0);
  endtask

  task automatic run_vectors(input string tag, output int nwin, output int nfe);
    nwin = 0;
    nfe  = 0;
    foreach (q[i]) begin
      @(negedge clk);
      sif.pix_valid   = q[i].v;
      sif.frame_start = q[i].fs;
      sif.pix_in      = q[i].pix;
      @(posedge clk);
      #1;
      check($sformatf("%s[%0d].win_valid", tag, i), 72'(sif.win_valid), 72'(q[i].wv));
      check($sformatf("%s[%0d].frame_end", tag, i), 72'(sif.frame_end), 72'(q[i].fe));
      check($sformatf("%s[%0d].p9", tag, i), 72'(sif.p9), 72'(q[i].p[8]));
      if (q[i].chk)
        check($sformatf("%s[%0d].window", tag, i),
              {sif.p9, sif.p8, sif.p7, sif.p6, sif.p5, sif.p4, sif.p3, sif.p2, sif.p1}, q[i].p);
      nwin += int'(sif.win_valid);
      nfe  += int'(sif.frame_end);
    end
    @(negedge clk);
    sif.pix_valid   = 1'b0;
    sif.frame_start = 1'b0;
    q.delete();
  endtask

  function automatic logic [7:0] pv(input int f, input int r, input int c);
    return 8'(r*5 + c*3 + f*41);
  endfunction

  task automatic run_big();
    logic [8:0][7:0] exp_w;
    int nwin;
    for (int f = 0; f < 3; f++) begin
      nwin = 0;
      for (int r = 0; r < 64; r++) begin
        for (int c = 0; c < 64; c++) begin
          while ($urandom_range(0, 3) == 0) begin
            @(negedge clk);
            bif.pix_valid   = 1'b0;
            bif.frame_start = 1'($urandom_range(0, 1));
            bif.pix_in      = 8'($urandom);
            @(posedge clk);
            #1;
            check($sformatf("big.f%0d.stall(%0d,%0d)", f, r, c),
                  72'({bif.win_valid, bif.frame_end}), 72'(0));
          end
          @(negedge clk);
          bif.pix_valid   = 1'b1;
          bif.frame_start = (f == 0 && r == 0 && c == 0);
          bif.pix_in      = pv(f, r, c);
          @(posedge clk);
          #1;
          check($sformatf("big.f%0d.flags(%0d,%0d)", f, r, c),
                72'({bif.win_valid, bif.frame_end}),
                72'({(r >= 2 && c >= 2), (r == 63 && c == 63)}));
          if (r >= 2 && c >= 2) begin
            for (int i = 0; i < 3; i++)
              for (int j = 0; j < 3; j++)
                exp_w[i*3+j] = pv(f, r-2+i, c-2+j);
            check($sformatf("big.f%0d.window(%0d,%0d)", f, r, c),
                  {bif.p9, bif.p8, bif.p7, bif.p6, bif.p5, bif.p4, bif.p3, bif.p2, bif.p1}, exp_w);
          end
          nwin += int'(bif.win_valid);
        end
      end
      check($sformatf("big.f%0d.window_count", f), 72'(nwin), 72'(62*62));
    end
    @(negedge clk);
    bif.pix_valid   = 1'b0;
    bif.frame_start = 1'b0;
  endtask

  initial begin
    int nwin, nfe;
    sif.pix_valid = 1'b0; sif.frame_start = 1'b0; sif.pix_in = 8'h00;
    bif.pix_valid = 1'b0; bif.frame_start = 1'b0; bif.pix_in = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("reset.flags", 72'({sif.win_valid, sif.frame_end}), 72'(0));
    check("reset.window", {sif.p9, sif.p8, sif.p7, sif.p6, sif.p5, sif.p4, sif.p3, sif.p2, sif.p1}, 72'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Continuous frame.
    push_frame(8'h00, 1'b1);
    run_vectors("frameA", nwin, nfe);
    check("frameA.windows", 72'(nwin), 72'(4));
    check("frameA.frame_ends", 72'(nfe), 72'(1));

    // Stall after (2,2); frame_start without pix_valid in the middle is ignored.
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        push_beat(8'h00, r, c, r == 0 && c == 0);
        if (r == 2 && c == 2) begin
          push_stall(1'b0);
          push_stall(1'b1);
          push_stall(1'b0);
        end
      end
    run_vectors("stall", nwin, nfe);
    check("stall.windows", 72'(nwin), 72'(4));
    check("stall.frame_ends", 72'(nfe), 72'(1));

    // Frame 1 aborted by frame_start at beat (3,1), then full frame 2.
    for (int k = 0; k < 13; k++) push_beat(8'h00, k / 4, k % 4, k == 0);
    push_frame(8'h80, 1'b1);
    run_vectors("restart", nwin, nfe);
    check("restart.windows", 72'(nwin), 72'(6));
    check("restart.frame_ends", 72'(nfe), 72'(1));

    // Asynchronous reset during row 2 while a window is being shown.
    for (int k = 0; k < 11; k++) push_beat(8'h00, k / 4, k % 4, k == 0);
    run_vectors("prereset", nwin, nfe);
    check("prereset.windows", 72'(nwin), 72'(1));
    sif.pix_valid = 1'b1; sif.pix_in = 8'h23;
    @(posedge clk);
    #1;
    check("prereset.win_valid", 72'(sif.win_valid), 72'(1));
    check("prereset.p9", 72'(sif.p9), 72'(8'h23));
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset.flags", 72'({sif.win_valid, sif.frame_end}), 72'(0));
    check("async_reset.window", {sif.p9, sif.p8, sif.p7, sif.p6, sif.p5, sif.p4, sif.p3, sif.p2, sif.p1}, 72'(0));
    @(negedge clk);
    sif.pix_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    push_frame(8'h10, 1'b0);
    run_vectors("postreset", nwin, nfe);
    check("postreset.windows", 72'(nwin), 72'(4));
    check("postreset.frame_ends", 72'(nfe), 72'(1));

    // Two frames back-to-back, the second relying on counter wrap.
    push_frame(8'h00, 1'b1);
    push_frame(8'h40, 1'b0);
    run_vectors("b2b", nwin, nfe);
    check("b2b.windows", 72'(nwin), 72'(8));
    check("b2b.frame_ends", 72'(nfe), 72'(2));

    run_big();

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule

// File: doc/line_window_3x3.md
LINE_WINDOW_3X3 -- requirements
Module: line_window_3x3

Interface
REQ-001 Parameter: IMG_WIDTH, default 64, pixels per line (>= 3).
REQ-002 Parameter: IMG_HEIGHT, default 64, lines per frame (>= 3).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 pix_in  input  8  raster-order pixel, unsigned.
REQ-006 pix_valid  input  1  pix_in valid this cycle; no backpressure, every valid beat is accepted.
REQ-007 frame_start  input  1  qualified by pix_valid; marks that beat as pixel (row 0, col 0).
REQ-008 p1, p2, p3  output  8 each  window top row (oldest line), left to right.
REQ-009 p4, p5, p6  output  8 each  window middle row, left to right.
REQ-010 p7, p8, p9  output  8 each  window bottom row (current line), left to right; p9 is the newest pixel.
REQ-011 win_valid  output  1  p1..p9 form a complete, valid 3x3 window this cycle.
REQ-012 frame_end  output  1  one-cycle pulse coincident with the window that contains the last pixel of the frame.

Function
REQ-013 Pixel counters col (0..IMG_WIDTH-1) and row (0..IMG_HEIGHT-1) advance only on pix_valid beats.
- col wraps from IMG_WIDTH-1 to 0 and increments row.
- At (IMG_HEIGHT-1, IMG_WIDTH-1), both counters return to 0.
REQ-014 Two line buffers of IMG_WIDTH x 8 hold lines row-1 and row-2; on each accepted beat the column entry is read before it is overwritten (read-before-write).
REQ-015 Window shift on each accepted beat:
- p1<-p2, p2<-p3, p3<-line(row-2)[col]
- p4<-p5, p5<-p6, p6<-line(row-1)[col]
- p7<-p8, p8<-p9, p9<-pix_in
REQ-016 Outputs are registered; win_valid asserts exactly 1 cycle after the accepted beat at (row >= 2, col >= 2), otherwise 0.
- No border padding.
- A frame yields (IMG_HEIGHT-2)*(IMG_WIDTH-2) windows.
REQ-017 The window is centred on pixel (row-1, col-1) of the completing beat.
REQ-018 FSM states:
- FILL: row < 2; win_valid never asserted.
- RUN: row >= 2.
- Transitions: FILL->RUN on the beat that completes row 1; RUN->FILL on the beat at frame end or on frame_start.
REQ-019 frame_start with pix_valid forces that beat to (0,0) regardless of counter state. The FSM enters FILL, and partial-frame data is never emitted in a window.
REQ-020 frame_start with pix_valid low is ignored.
REQ-021 pix_valid low (stall):
- counters, line buffers and p1..p9 hold;
- win_valid and frame_end are 0 the following cycle.
REQ-022 Windows never straddle lines. At col 0 and col 1 of a line, win_valid stays 0 even though the shift registers contain the previous line's tail.
REQ-023 frame_end asserts together with win_valid for the window completed by the beat at (IMG_HEIGHT-1, IMG_WIDTH-1).
REQ-024 Latency: 1 cycle from the completing pix_valid beat to win_valid. Throughput: 1 window per cycle in RUN with continuous input.

Reset
REQ-025 On rst_n low, immediately and independent of clk:
- p1..p9 = 0, win_valid = 0, frame_end = 0;
- row = col = 0; FSM = FILL.
REQ-026 Line buffer contents are not reset. The FILL state guarantees stale contents are never output.
REQ-027 Reset asserted mid-frame aborts the frame. The first accepted beat after release is pixel (0,0).

Verification (IMG_WIDTH=4, IMG_HEIGHT=4, pixel value = row*16+col)
REQ-028 Continuous frame, frame_start on first beat -> first win_valid 1 cycle after beat (2,2) with p1..p9 = 00,01,02,10,11,12,20,21,22. Exactly 4 windows are produced; the last has p9 = 0x33 and frame_end = 1.
REQ-029 Same frame with pix_valid low for 3 cycles after beat (2,2) -> the window is still emitted once, outputs hold during the stall, and the next window (p9 = 0x23) follows the next accepted beat.
REQ-030 frame_start reasserted at beat (3,1) of frame 1, then a full frame 2 -> no window mixes frames. The first frame-2 window appears after frame-2 beat (2,2) with frame-2 values only.
REQ-031 rst_n pulsed low during row 2 -> outputs are 0 asynchronously. The subsequent frame produces exactly 4 correct windows.
REQ-032 Two frames back-to-back with no idle cycles -> 8 windows, 2 frame_end pulses, and win_valid low for rows 0-1 of frame 2.
REQ-033 IMG_WIDTH=64, random stalls over 3 frames -> every window matches the scoreboard, and each frame yields 62*62 windows.
